// File: rtl/osc_ctrl_mon_if.sv
// rtl/osc_ctrl_mon_if.sv - oscillator enable/clock and measurement result bundle
interface osc_ctrl_mon_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 en;
    logic                 osc_clk;
    logic                 osc_dis;
    logic                 osc_ok;
    logic                 fault;
    logic [CNT_WIDTH-1:0] meas_count;
    logic                 meas_valid;

    modport master (
        output en, osc_clk,
        input  osc_dis, osc_ok, fault, meas_count, meas_valid
    );

    modport slave (
        input  en, osc_clk,
        output osc_dis, osc_ok, fault, meas_count, meas_valid
    );
endinterface

// File: rtl/osc_ctrl_mon.sv
// rtl/osc_ctrl_mon.sv - oscillator enable sequencer and windowed frequency monitor
// Optional OSC_AUTO_RESTART_EN: power-cycle the oscillator after a faulty window instead of halting.
module osc_ctrl_mon #(
    parameter int SETTLE_CYCLES = 256,
    parameter int WINDOW_CYCLES = 1024,
    parameter int CNT_WIDTH     = 16,
    parameter int MIN_COUNT     = 100,
    parameter int MAX_COUNT     = 140,
    parameter int OFF_CYCLES    = 64
) (
    input  logic             clk,
    input  logic             rst,
    osc_ctrl_mon_if.slave    bus
);
    localparam int MAX_A   = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int MAX_CYC = (MAX_A > OFF_CYCLES) ? MAX_A : OFF_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    localparam logic [TMR_W-1:0]     SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]     WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] MIN_C       = CNT_WIDTH'(MIN_COUNT);
    localparam logic [CNT_WIDTH-1:0] MAX_C       = CNT_WIDTH'(MAX_COUNT);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT     = {CNT_WIDTH{1'b1}};
`ifdef OSC_AUTO_RESTART_EN
    localparam logic [TMR_W-1:0]     OFF_LAST    = TMR_W'(OFF_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_OFF,
        ST_SETTLE,
        ST_MEASURE,
`ifdef OSC_AUTO_RESTART_EN
        ST_RESTART,
`endif
        ST_FAULT
    } state_t;

    state_t               state;
    logic [TMR_W-1:0]     timer;
    logic [CNT_WIDTH-1:0] edge_cnt;
    logic [2:0]           sync_q;    // [0],[1] synchronizer, [2] previous synchronized value
    logic                 osc_dis_q;
    logic                 osc_ok_q;
    logic                 fault_q;
    logic [CNT_WIDTH-1:0] meas_count_q;
    logic                 meas_valid_q;

    logic                 osc_rise;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 in_range;

    assign osc_rise = sync_q[1] & ~sync_q[2];
    // The edge seen on the final window cycle is folded into the published count.
    assign cnt_next = (osc_rise && (edge_cnt != CNT_SAT)) ? edge_cnt + CNT_WIDTH'(1) : edge_cnt;
    assign in_range = (cnt_next >= MIN_C) && (cnt_next <= MAX_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_OFF;
            timer        <= '0;
            edge_cnt     <= '0;
            sync_q       <= '0;
            osc_dis_q    <= 1'b1;
            osc_ok_q     <= 1'b0;
            fault_q      <= 1'b0;
            meas_count_q <= '0;
            meas_valid_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[1:0], bus.osc_clk};
            meas_valid_q <= 1'b0;
            if (!bus.en) begin
                state     <= ST_OFF;
                timer     <= '0;
                edge_cnt  <= '0;
                osc_dis_q <= 1'b1;
                osc_ok_q  <= 1'b0;
                fault_q   <= 1'b0;
            end else begin
                case (state)
                    ST_OFF: begin
                        state     <= ST_SETTLE;
                        timer     <= '0;
                        osc_dis_q <= 1'b0;
                    end
                    ST_SETTLE: begin
                        if (timer == SETTLE_LAST) begin
                            state    <= ST_MEASURE;
                            timer    <= '0;
                            edge_cnt <= '0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    ST_MEASURE: begin
                        if (timer == WINDOW_LAST) begin
                            timer        <= '0;
                            edge_cnt     <= '0;
                            meas_count_q <= cnt_next;
                            osc_ok_q     <= in_range;
                            fault_q      <= !in_range;
                            meas_valid_q <= 1'b1;
                            if (!in_range) begin
`ifdef OSC_AUTO_RESTART_EN
                                state     <= ST_RESTART;
                                osc_dis_q <= 1'b1;
`else
                                state     <= ST_FAULT;
`endif
                            end
                        end else begin
                            timer    <= timer + TMR_W'(1);
                            edge_cnt <= cnt_next;
                        end
                    end
`ifdef OSC_AUTO_RESTART_EN
                    ST_RESTART: begin
                        if (timer == OFF_LAST) begin
                            state     <= ST_SETTLE;
                            timer     <= '0;
                            osc_dis_q <= 1'b0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
`endif
                    ST_FAULT: begin
                        state <= ST_FAULT;
                    end
                    default: begin
                        state     <= ST_OFF;
                        osc_dis_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.osc_dis    = osc_dis_q;
    assign bus.osc_ok     = osc_ok_q;
    assign bus.fault      = fault_q;
    assign bus.meas_count = meas_count_q;
    assign bus.meas_valid = meas_valid_q;
endmodule

// File: tb/tb_osc_ctrl_mon.sv
// tb/tb_osc_ctrl_mon.sv - randomized and directed checks of osc_ctrl_mon against a window-level model
module tb_osc_ctrl_mon;
    localparam int S    = 8;
    localparam int W    = 64;
    localparam int CW   = 8;
    localparam int MINC = 14;
    localparam int MAXC = 18;
    localparam int OFFC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    osc_ctrl_mon_if #(.CNT_WIDTH(CW)) bus ();
    osc_ctrl_mon_if #(.CNT_WIDTH(4))  sbus ();

    osc_ctrl_mon #(
        .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_WIDTH(CW),
        .MIN_COUNT(MINC), .MAX_COUNT(MAXC), .OFF_CYCLES(OFFC)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    osc_ctrl_mon #(
        .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_WIDTH(4),
        .MIN_COUNT(2), .MAX_COUNT(14), .OFF_CYCLES(OFFC)
    ) dut_sat (
        .clk(clk), .rst(rst), .bus(sbus)
    );

    assign sbus.en      = bus.en;
    assign sbus.osc_clk = bus.osc_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // osc_clk generator: high for osc_hi cycles, low for osc_lo; osc_hi==0 means stuck low
    int osc_hi = 2;
    int osc_lo = 2;
    initial begin
        bus.osc_clk = 1'b0;
        forever begin
            if (osc_hi == 0) begin
                bus.osc_clk = 1'b0;
                @(negedge clk);
            end else begin
                bus.osc_clk = 1'b1;
                repeat (osc_hi) @(negedge clk);
                bus.osc_clk = 1'b0;
                repeat (osc_lo) @(negedge clk);
            end
        end
    end

    // Reference model: run phases as arithmetic on the cycle index, edge counts from sample history
    typedef enum {M_OFF, M_RUN, M_WAIT, M_HALT} mmode_t;
    mmode_t m_mode = M_OFF;
    logic   hist [0:32767];
    int     cyc = 0;
    int     run_start = 0;
    int     wait_until = 0;
    logic   e_dis = 1'b1, e_ok = 1'b0, e_fault = 1'b0, e_valid = 1'b0;
    int     e_count = 0;

    // A rise reaches the counter two samples late (two synchronizer stages)
    function automatic int window_edges(input int last);
        int c = 0;
        for (int k = last - W + 1; k <= last; k++)
            if (hist[(k - 2) & 'h7fff] && !hist[(k - 3) & 'h7fff]) c++;
        return c;
    endfunction

    task automatic model_step();
        int t;
        int raw;
        hist[cyc & 'h7fff] = bus.osc_clk;
        e_valid = 1'b0;
        if (rst) begin
            m_mode = M_OFF; e_dis = 1'b1; e_ok = 1'b0; e_fault = 1'b0; e_count = 0;
        end else if (!bus.en) begin
            m_mode = M_OFF; e_dis = 1'b1; e_ok = 1'b0; e_fault = 1'b0;
        end else begin
            case (m_mode)
                M_OFF: begin m_mode = M_RUN; run_start = cyc; e_dis = 1'b0; end
                M_RUN: begin
                    t = cyc - run_start;
                    if (t > S && ((t - S) % W) == 0) begin
                        raw     = window_edges(cyc);
                        e_count = (raw > 255) ? 255 : raw;
                        e_ok    = (e_count >= MINC) && (e_count <= MAXC);
                        e_fault = !e_ok;
                        e_valid = 1'b1;
                        if (!e_ok) begin
`ifdef OSC_AUTO_RESTART_EN
                            m_mode = M_WAIT; wait_until = cyc + OFFC; e_dis = 1'b1;
`else
                            m_mode = M_HALT;
`endif
                        end
                    end
                end
                M_WAIT: if (cyc == wait_until) begin m_mode = M_RUN; run_start = cyc; e_dis = 1'b0; end
                default: ;
            endcase
        end
        cyc++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk_eq("osc_dis",    bus.osc_dis,    e_dis);
            chk_eq("meas_valid", bus.meas_valid, e_valid);
            chk_eq("osc_ok",     bus.osc_ok,     e_ok);
            chk_eq("fault",      bus.fault,      e_fault);
            chk_eq("meas_count", bus.meas_count, e_count);
        end
    end

    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.meas_valid && n < limit);
    endtask

    task automatic en_toggle();
        bus.en = 1'b0;
        repeat (2) @(negedge clk);
        bus.en = 1'b1;
    endtask

    initial begin
        int n;
        int r;
        rst    = 1'b1;
        bus.en = 1'b1;

        // 1: reset with en held, clk/4 oscillator
        repeat (3) @(negedge clk);
        chk_eq("rst_dis",   bus.osc_dis,    1);
        chk_eq("rst_ok",    bus.osc_ok,     0);
        chk_eq("rst_fault", bus.fault,      0);
        chk_eq("rst_count", bus.meas_count, 0);
        chk_eq("rst_valid", bus.meas_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_eq("t1_dis_fall", bus.osc_dis, 0);
        wait_pulse(200, n);
        chk_eq("t1_first_lat", n, S + W);
        chk_eq("t1_count", bus.meas_count, 16);
        chk_eq("t1_ok",    bus.osc_ok, 1);
        wait_pulse(200, n);
        chk_eq("t1_period", n, W);

        // 2: clk/8 oscillator is out of range
        osc_hi = 4; osc_lo = 4;
        en_toggle();
        wait_pulse(200, n);
        chk_eq("t2_valid", bus.meas_valid, 1);
        chk_eq("t2_count", bus.meas_count, 8);
        chk_eq("t2_fault", bus.fault, 1);
`ifndef OSC_AUTO_RESTART_EN
        n = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.meas_valid) n++;
        end
        chk_eq("t2_halt_pulses", n, 0);
        chk_eq("t2_halt_dis",    bus.osc_dis, 0);
`endif

        // 3: stuck oscillator
        osc_hi = 0;
        en_toggle();
        wait_pulse(200, n);
        chk_eq("t3_count", bus.meas_count, 0);
        chk_eq("t3_fault", bus.fault, 1);
        osc_hi = 2; osc_lo = 2;
`ifdef OSC_AUTO_RESTART_EN
        n = 0;
        while (bus.osc_dis && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk_eq("t3_off_cycles", n, OFFC);
`else
        en_toggle();
`endif
        wait_pulse(200, n);
        chk_eq("t3_recover_ok", bus.osc_ok, 1);

        // 4: en dropped mid-window
        wait_pulse(200, n);
        repeat (29) @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        chk_eq("t4_dis",   bus.osc_dis, 1);
        chk_eq("t4_ok",    bus.osc_ok,  0);
        chk_eq("t4_fault", bus.fault,   0);
        repeat (3) @(negedge clk);
        bus.en = 1'b1;
        @(negedge clk);
        wait_pulse(200, n);
        chk_eq("t4_resettle_lat", n, S + W);

        // 5: saturating 4-bit counter
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sbus.meas_valid && n < 200);
        chk_eq("t5_valid", sbus.meas_valid, 1);
        chk_eq("t5_count", sbus.meas_count, 15);
        chk_eq("t5_ok",    sbus.osc_ok,     0);
        chk_eq("t5_fault", sbus.fault,      1);

        // 6: reset during measurement
        wait_pulse(200, n);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("t6_dis",   bus.osc_dis,    1);
        chk_eq("t6_ok",    bus.osc_ok,     0);
        chk_eq("t6_count", bus.meas_count, 0);
        rst = 1'b0;
        wait_pulse(200, n);
        chk_eq("t6_ok_after", bus.osc_ok, 1);

        // randomized frequencies, en drops and resets, checked cycle by cycle by the model
        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                osc_hi = 0;
            end else begin
                osc_hi = $urandom_range(1, 5);
                osc_lo = $urandom_range(1, 5);
                if (osc_hi + osc_lo < 3) osc_lo = 2;
            end
            repeat ($urandom_range(40, 400)) @(negedge clk);
            r = $urandom_range(0, 9);
            if (r < 3) begin
                bus.en = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                bus.en = 1'b1;
            end else if (r == 3) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end
        end
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
